// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: shared widths, opcodes and request/response records for mem_req_ctrl
package mem_req_ctrl_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } resp_t;
endpackage

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: request, memory and response buses of mem_req_ctrl; slave is the controller
interface mem_req_ctrl_if;
   import mem_req_ctrl_pkg::*;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wen;
   logic              mem_ren;
   logic [DATA_W-1:0] mem_odata;
   logic              resp_valid;
   logic              resp_ready;
   logic [ADDR_W-1:0] resp_addr;
   logic [DATA_W-1:0] resp_data;
   modport master (
      output req_valid, req_wr, req_addr, req_data, resp_ready, mem_odata,
      input  req_ready, mem_addr, mem_data, mem_wen, mem_ren, resp_valid, resp_addr, resp_data
   );
   modport slave (
      input  req_valid, req_wr, req_addr, req_data, resp_ready, mem_odata,
      output req_ready, mem_addr, mem_data, mem_wen, mem_ren, resp_valid, resp_addr, resp_data
   );
endinterface

// File: rtl/mem_req_ctrl_sync_fifo.sv
// mem_req_ctrl_sync_fifo: synchronous FIFO with extra-bit pointers, synchronous clear and occupancy count
module mem_req_ctrl_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [W-1:0]            din_i,
   output logic [W-1:0]            dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   // pointer next-state: clear wins, otherwise advance on push/pop
   always_comb begin
      wr_d = clr_i ? '0 : wr_q + (AW+1)'(push_i);
      rd_d = clr_i ? '0 : rd_q + (AW+1)'(pop_i);
   end
   // pointer registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   // storage is reset-free: entries are only observed while counted valid
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
   assign count_o = wr_q - rd_q;
   assign full_o  = count_o == (AW+1)'(DEPTH);
   assign empty_o = wr_q == rd_q;
   assign dout_o  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: in-order request queue, credit-gated read issue and response buffer; MEM_REQ_BYPASS_EN enables empty-queue bypass
module mem_req_ctrl
   import mem_req_ctrl_pkg::*;
#(
   parameter int REQ_DEPTH  = 4,
   parameter int RESP_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   output logic          busy_o,
   mem_req_ctrl_if.slave bus
);
   localparam int RCW = $clog2(RESP_DEPTH);
   localparam int QCW = $clog2(REQ_DEPTH);
   req_t              in_req, head, iss;
   resp_t             rsp_in, rsp_head;
   logic              rq_push, rq_pop, rq_full, rq_empty;
   logic [QCW:0]      rq_cnt;
   logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
   logic [RCW:0]      rsp_cnt;
   logic              credit_ok, head_go, byp, go;
   logic              rd_inflight_q, rd_inflight_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   mem_req_ctrl_sync_fifo #(.W($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
      .clk(clk), .rst(rst), .clr_i(flush_i), .push_i(rq_push), .pop_i(rq_pop),
      .din_i(in_req), .dout_o(head), .full_o(rq_full), .empty_o(rq_empty), .count_o(rq_cnt)
   );

   mem_req_ctrl_sync_fifo #(.W($bits(resp_t)), .DEPTH(RESP_DEPTH)) u_resp_q (
      .clk(clk), .rst(rst), .clr_i(1'b0), .push_i(rsp_push), .pop_i(rsp_pop),
      .din_i(rsp_in), .dout_o(rsp_head), .full_o(rsp_full), .empty_o(rsp_empty), .count_o(rsp_cnt)
   );

   // issue selection, credit check, memory strobes and response port
   always_comb begin
      bus.resp_valid = !rsp_empty;
      rsp_pop        = bus.resp_valid && bus.resp_ready;
      credit_ok      = ({1'b0, rsp_cnt} + (RCW+2)'(rd_inflight_q) - (RCW+2)'(rsp_pop)) < (RCW+2)'(RESP_DEPTH);
      in_req         = '{wr: bus.req_wr, addr: bus.req_addr, data: bus.req_data};
      head_go        = !rq_empty && !flush_i && (head.wr == OP_WRITE || credit_ok);
`ifdef MEM_REQ_BYPASS_EN
      byp            = rq_empty && !flush_i && bus.req_valid && (bus.req_wr == OP_WRITE || credit_ok);
`else
      byp            = 1'b0;
`endif
      go             = head_go || byp;
      iss            = head_go ? head : in_req;
      bus.mem_wen    = go && iss.wr == OP_WRITE;
      bus.mem_ren    = go && iss.wr != OP_WRITE;
      bus.mem_addr   = go ? iss.addr : '0;
      bus.mem_data   = go ? iss.data : '0;
      bus.req_ready  = !rq_full;
      rq_push        = bus.req_valid && !rq_full && !flush_i && !byp;
      rq_pop         = head_go;
      rd_inflight_d  = bus.mem_ren;
      rd_addr_d      = bus.mem_ren ? bus.mem_addr : rd_addr_q;
      rsp_push       = rd_inflight_q;
      rsp_in         = '{addr: rd_addr_q, data: bus.mem_odata};
      bus.resp_addr  = bus.resp_valid ? rsp_head.addr : '0;
      bus.resp_data  = bus.resp_valid ? rsp_head.data : '0;
      busy_o         = rq_cnt != '0 || rd_inflight_q || bus.resp_valid;
   end

   // track the read whose data the memory returns next cycle
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rd_inflight_q <= 1'b0;
         rd_addr_q     <= '0;
      end else begin
         rd_inflight_q <= rd_inflight_d;
         rd_addr_q     <= rd_addr_d;
      end

   // credits must keep the response buffer from ever overflowing
   assert property (@(posedge clk) disable iff (!rst) rsp_push |-> (!rsp_full || rsp_pop));
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: table-driven and scenario checks of mem_req_ctrl against a behavioural 16x8 memory
module tb_mem_req_ctrl;
   import mem_req_ctrl_pkg::*;

`ifdef MEM_REQ_BYPASS_EN
   localparam int BYP = 1;
   localparam int LAT = 2;
`else
   localparam int BYP = 0;
   localparam int LAT = 3;
`endif

   typedef struct packed {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic busy;
   logic [7:0] mem [16] = '{default: 8'h00};
   logic [11:0] rq[$];
   logic [11:0] wq[$];
   int checks = 0, errors = 0;
   int wen_cnt = 0, ren_cnt = 0, resp_cnt = 0;
   vec_t vt [12];
   vec_t ct [6];

   mem_req_ctrl_if bus ();

   mem_req_ctrl #(.REQ_DEPTH(4), .RESP_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .busy_o(busy), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_data;
      if (bus.mem_ren) bus.mem_odata <= mem[bus.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bad(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected none", name, act);
   endtask

   always @(negedge clk) if (rst) begin
      if (bus.mem_wen && bus.mem_ren) bad("both_strobes", 32'h3);
      if (bus.mem_ren) ren_cnt++;
      if (bus.mem_wen) begin
         wen_cnt++;
         if (wq.size() == 0) bad("unexpected_write", {bus.mem_addr, bus.mem_data});
         else chk("write_strobe", {bus.mem_addr, bus.mem_data}, wq.pop_front());
      end
      if (bus.resp_valid && bus.resp_ready) begin
         resp_cnt++;
         if (rq.size() == 0) bad("unexpected_resp", {bus.resp_addr, bus.resp_data});
         else chk("resp", {bus.resp_addr, bus.resp_data}, rq.pop_front());
      end
   end

   task automatic send(input logic wr, input logic [3:0] a, input logic [7:0] d, input logic [7:0] e, input logic track);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = a;
      bus.req_data  = d;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) bad("accept_timeout", {28'h0, a});
      else if (track) begin
         if (wr == OP_WRITE) wq.push_back({a, d});
         else rq.push_back({a, e});
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) bad("drain_timeout", rq.size() + wq.size());
      @(posedge clk);
      #1;
   endtask

   task automatic rst_chk(input string t);
      chk({t, "_req_ready"}, bus.req_ready, 1);
      chk({t, "_mem_wen"}, bus.mem_wen, 0);
      chk({t, "_mem_ren"}, bus.mem_ren, 0);
      chk({t, "_mem_addr"}, bus.mem_addr, 0);
      chk({t, "_mem_data"}, bus.mem_data, 0);
      chk({t, "_resp_valid"}, bus.resp_valid, 0);
      chk({t, "_resp_addr"}, bus.resp_addr, 0);
      chk({t, "_resp_data"}, bus.resp_data, 0);
      chk({t, "_busy"}, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat, r0, n0, w0, seen;
      vt[0]  = '{OP_WRITE, 4'h2, 8'h11, 8'h00};
      vt[1]  = '{OP_WRITE, 4'hA, 8'h22, 8'h00};
      vt[2]  = '{OP_READ,  4'hA, 8'h00, 8'h22};
      vt[3]  = '{OP_READ,  4'h2, 8'h00, 8'h11};
      vt[4]  = '{OP_READ,  4'h3, 8'h00, 8'h5A};
      vt[5]  = '{OP_WRITE, 4'h3, 8'hC3, 8'h00};
      vt[6]  = '{OP_READ,  4'h3, 8'h00, 8'hC3};
      vt[7]  = '{OP_READ,  4'h7, 8'h00, 8'h00};
      vt[8]  = '{OP_WRITE, 4'hF, 8'h01, 8'h00};
      vt[9]  = '{OP_WRITE, 4'hF, 8'h02, 8'h00};
      vt[10] = '{OP_READ,  4'hF, 8'h00, 8'h02};
      vt[11] = '{OP_READ,  4'hB, 8'h00, 8'h00};
      ct[0]  = '{OP_READ,  4'h2, 8'h00, 8'h11};
      ct[1]  = '{OP_READ,  4'hA, 8'h00, 8'h22};
      ct[2]  = '{OP_READ,  4'h3, 8'h00, 8'hC3};
      ct[3]  = '{OP_READ,  4'hF, 8'h00, 8'h02};
      ct[4]  = '{OP_READ,  4'h7, 8'h00, 8'h00};
      ct[5]  = '{OP_READ,  4'h2, 8'h00, 8'h11};
      rst = 1'b0;
      flush = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_wr = OP_READ;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.resp_ready = 1'b1;
      #3;
      rst_chk("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      send(OP_WRITE, 4'h3, 8'h5A, 8'h00, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_wr    = OP_READ;
      bus.req_addr  = 4'h3;
      bus.req_data  = 8'h00;
      rq.push_back({4'h3, 8'h5A});
      @(negedge clk);
      chk("accept_cycle_ren", bus.mem_ren, BYP);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.resp_valid && lat < 10);
      chk("read_latency", lat, LAT);
      drain();

      r0 = resp_cnt;
      w0 = wen_cnt;
      for (int i = 0; i < 12; i++) send(vt[i].wr, vt[i].addr, vt[i].data, vt[i].exp, 1'b1);
      drain();
      chk("table_resp_count", resp_cnt - r0, 7);
      chk("table_write_count", wen_cnt - w0, 5);

      bus.resp_ready = 1'b0;
      r0 = resp_cnt;
      n0 = ren_cnt;
      for (int i = 0; i < 6; i++) send(ct[i].wr, ct[i].addr, ct[i].data, ct[i].exp, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_wr    = OP_READ;
      bus.req_addr  = 4'h5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_req_ready", bus.req_ready, 0);
         chk("stall_resp_head", {bus.resp_valid, bus.resp_addr, bus.resp_data}, {1'b1, 4'h2, 8'h11});
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("stall_ren_count", ren_cnt - n0, 2);
      bus.resp_ready = 1'b1;
      drain();
      chk("stall_resp_count", resp_cnt - r0, 6);

      r0 = resp_cnt;
      n0 = ren_cnt;
      send(OP_READ, 4'h2, 8'h00, 8'h11, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_wr    = OP_READ;
      bus.req_addr  = 4'hA;
      if (BYP != 0) rq.push_back({4'hA, 8'h22});
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.req_addr = 4'h3;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_no_issue", {bus.mem_wen, bus.mem_ren}, 0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      flush = 1'b0;
      drain();
      chk("flush_ren_count", ren_cnt - n0, 1 + BYP);
      chk("flush_resp_count", resp_cnt - r0, 1 + BYP);
      chk("flush_busy", busy, 0);

      send(OP_READ, 4'h2, 8'h00, 8'h00, 1'b0);
      if (BYP == 0) begin
         @(posedge clk);
         #1;
      end
      chk("busy_inflight", busy, 1);
      #1 rst = 1'b0;
      #1 rst_chk("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.resp_valid) seen = 1;
      end
      chk("no_resp_after_reset", seen, 0);
      chk("idle_after_reset", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request-side controller that sits directly upstream of the banked 16x8 memory (two 8-entry subarrays selected by addr[3], 1-cycle registered read).
- Buffers read/write requests from a valid/ready producer in an in-order FIFO and drives the memory's addr/data/wen/ren.
- Captures read data one cycle after issue and returns it on a valid/ready response port.
- Credit-based flow control: a read is never issued unless its response has a guaranteed slot.

Parameters:
- ADDR_W, 4, memory address width (bit ADDR_W-1 is the bank select downstream).
- DATA_W, 8, data width.
- REQ_DEPTH, 4, request FIFO entries (power of two, >=2).
- RESP_DEPTH, 2, response buffer entries (power of two, >=2).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  FIFO not full.
- req_wr  input  1  1=write, 0=read.
- req_addr  input  ADDR_W  request address.
- req_data  input  DATA_W  write data (ignored for reads).
- flush  input  1  drop all queued, not-yet-issued requests.
- mem_addr  output  ADDR_W  to memory addr.
- mem_data  output  DATA_W  to memory data.
- mem_wen  output  1  to memory wen.
- mem_ren  output  1  to memory ren.
- mem_odata  input  DATA_W  memory read data, valid the cycle after mem_ren.
- resp_valid  output  1  read response available.
- resp_ready  input  1  consumer accepts response.
- resp_addr  output  ADDR_W  address of the returned read.
- resp_data  output  DATA_W  returned read data.
- busy  output  1  FIFO non-empty, or read in flight, or response buffered.

Behaviour:
- Reset (rst low, asynchronous): FIFO and response buffer empty; rd_inflight=0.
  - Reset values: req_ready=1, mem_wen=0, mem_ren=0, mem_addr=0, mem_data=0, resp_valid=0, resp_addr=0, resp_data=0, busy=0.
  - Reset mid-operation discards everything, including an in-flight read; no response is produced for it.
- Accept: req_valid&req_ready at a rising edge pushes {wr,addr,data}. req_ready = !full, registered count, no same-cycle pop credit.
- Issue (combinational from FIFO head):
  - Head write: always issues; mem_wen=1, pop.
  - Head read: issues only if resp_cnt + rd_inflight - (resp_valid&resp_ready) < RESP_DEPTH; then mem_ren=1, pop.
  - At most one op per cycle. mem_addr/mem_data follow the head when an op issues, else 0.
- Read pipeline: issue at cycle t -> rd_inflight=1 with latched addr in t+1 -> mem_odata sampled at end of t+1 -> resp_valid in t+2.
  - Without bypass, read latency from accept edge to resp_valid is 3 cycles.
- Ordering: strict program order. A write to A followed by a read of A returns the new data, because the memory write lands before the next-cycle read.
- Response buffer: FIFO of RESP_DEPTH {addr,data}. resp_* show the head. Pop on resp_valid&resp_ready. A simultaneous push and pop is allowed.
  - Credits guarantee the buffer never overflows; overflow is a design error, checked by assertion.
- Full/empty:
  - Push while full cannot happen because req_ready=0.
  - Issue while empty: no strobes.
  - Pointers wrap modulo depth, with an extra bit to tell full from empty.
- flush:
  - Empties the request FIFO at the edge.
  - Suppresses issue in the flush cycle (mem_wen=mem_ren=0).
  - Does not cancel rd_inflight or buffered responses.
  - A request pushed in the same cycle as flush is also dropped.
- busy = !fifo_empty | rd_inflight | resp_valid.

Optional Feature:
- MEM_REQ_BYPASS_EN:
  - Defined: when the FIFO is empty, flush=0, and the credit check passes, an incoming req_valid request issues to the memory in the same cycle without being pushed.
  - Read latency then drops to 2 cycles. req_ready is unchanged.
  - Undefined: every request goes through the FIFO, giving a minimum 1-cycle issue delay.

Decomposition:
- Shared package:
  - req_t struct {wr, addr, data} and resp_t struct {addr, data}.
  - Constants OP_READ=0 and OP_WRITE=1.
  - Default widths ADDR_W=4 and DATA_W=8.
- One natural sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count).
  - Instantiated twice: request queue and response buffer.

Test Plan:
- Write 0x5A to addr 0x3, then read 0x3 with resp_ready=1 -> mem_wen pulse with addr 3 and data 0x5A; resp_valid 3 cycles after the read is accepted, resp_addr=0x3, resp_data=0x5A.
- Writes 0x11 to 0x2 and 0x22 to 0xA (different banks), then reads 0xA, 0x2 -> responses in order: 0x22, then 0x11.
- resp_ready=0 and 4 reads queued -> exactly 2 mem_ren pulses, then stall; resp_valid held with data stable. Release resp_ready -> remaining 2 reads issue and all 4 responses return in order.
- Push 4 requests with issue blocked (resp_ready=0, buffer full) -> req_ready=0 after the 4th; a 5th req_valid is not accepted.
- 3 queued reads, assert flush the cycle after the first issues -> only 1 response returned; busy falls to 0 after it is popped.
- Assert rst low while a read is in flight -> all outputs take their reset values immediately; no resp_valid after release.
- With MEM_REQ_BYPASS_EN defined, a read to an empty FIFO -> mem_ren in the accept cycle; resp_valid 2 cycles later.
